// File: rtl/alu_exec_sequencer.sv
// Multicycle control/register stage feeding a 16-bit ALU.
// Owns an 8x16 register file; mv/mvi bypass the ALU.
module alu_exec_sequencer #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              run,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_IMM, S_EXEC, S_WB
  } state_t;

  state_t            state_q, state_d;
  logic [15:6]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] g_q, g_d;
  logic [3:0]        op_q, op_d;
  logic              done_q, done_d;
  logic              ill_q, ill_d;
  logic              wr_en;
  logic [DATA_W-1:0] rf_q [NREGS];

  logic [3:0] op;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       is_mv;
  logic       is_mvi;
  logic       is_alu;

  assign op     = ir_q[15:12];
  assign rx     = ir_q[11:9];
  assign ry     = ir_q[8:6];
  assign is_mv  = (op == 4'd1);
  assign is_mvi = (op == 4'd2);
  assign is_alu = (op >= 4'd5) && (op <= 4'd10);

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    g_d     = g_q;
    op_d    = 4'd0;
    done_d  = 1'b0;
    ill_d   = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          ir_d    = din[15:6];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = rf_q[rx];
        b_d = rf_q[ry];
        unique case (1'b1)
          is_mv: begin
            g_d     = rf_q[ry];
            state_d = S_WB;
          end
          is_mvi: state_d = S_IMM;
          is_alu: begin
            // opcode is registered so it is stable for all of EXEC
            op_d    = op;
            state_d = S_EXEC;
          end
          default: begin
            done_d  = 1'b1;
            ill_d   = 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end
      S_IMM: begin
        g_d     = din;
        state_d = S_WB;
      end
      S_EXEC: begin
        g_d     = alu_result;
        state_d = S_WB;
      end
      S_WB: begin
        wr_en   = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      g_q     <= '0;
      op_q    <= '0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      g_q     <= g_d;
      op_q    <= op_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
      if (wr_en) rf_q[rx] <= g_q;
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign illegal  = ill_q;
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Bench for alu_exec_sequencer: directed plan plus random
// instructions against a register-array reference model.
`timescale 1ns/1ps
module tb_alu_exec_sequencer;

  logic        clock;
  logic        resetn;
  logic        run;
  logic [15:0] din;
  logic [15:0] alu_result;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic        busy;
  logic        done;
  logic        illegal;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] ref_r [8];
  logic [15:0] obs_r [8];

  alu_exec_sequencer dut (
    .clock      (clock),
    .resetn     (resetn),
    .run        (run),
    .din        (din),
    .alu_result (alu_result),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  function automatic logic [15:0] alu_f(
    input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'd5:    return a + b;
      4'd6:    return a - b;
      4'd7:    return a & b;
      4'd8:    return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      4'd9:    return (b >= 16'd16) ? 16'd0 : (a << b[3:0]);
      4'd10:   return (b >= 16'd16) ? 16'd0 : (a >> b[3:0]);
      default: return 16'd0;
    endcase
  endfunction

  // external ALU
  always_comb alu_result = alu_f(alu_op, alu_a, alu_b);

  function automatic bit is_alu_op(input logic [3:0] op);
    return (op >= 4'd5) && (op <= 4'd10);
  endfunction

  function automatic bit is_illegal(input logic [3:0] op);
    return !(op == 4'd1 || op == 4'd2 || is_alu_op(op));
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
    if (op == 4'd1) return 2;
    if (op == 4'd2 || is_alu_op(op)) return 3;
    return 1;
  endfunction

  task automatic model_step(input logic [15:0] ins, input logic [15:0] imm);
    logic [3:0] op;
    logic [2:0] rx;
    logic [2:0] ry;
    op = ins[15:12]; rx = ins[11:9]; ry = ins[8:6];
    if (op == 4'd1) ref_r[rx] = ref_r[ry];
    else if (op == 4'd2) ref_r[rx] = imm;
    else if (is_alu_op(op)) ref_r[rx] = alu_f(op, ref_r[rx], ref_r[ry]);
  endtask

  task automatic sweep_regs();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = i[2:0];
      #1;
      obs_r[i] = dbg_data;
    end
  endtask

  // drives one instruction and records what the DUT did
  task automatic issue(input logic [15:0] ins, input logic [15:0] imm,
                       output int lat, output logic ill,
                       output logic busy_ok, output logic op_ok);
    logic [3:0] op;
    logic [2:0] rx;
    logic [2:0] ry;
    op = ins[15:12]; rx = ins[11:9]; ry = ins[8:6];
    @(negedge clock); din = ins; run = 1'b1;
    @(negedge clock); run = 1'b0; din = imm;
    lat = -1; ill = 1'b0; busy_ok = 1'b1; op_ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clock);
      if (is_alu_op(op) && k == 1) begin
        if (alu_op !== op || alu_a !== ref_r[rx] || alu_b !== ref_r[ry])
          op_ok = 1'b0;
      end else if (alu_op !== 4'd0) op_ok = 1'b0;
      if (done === 1'b1) begin
        lat = k;
        ill = illegal;
        if (busy !== 1'b0) busy_ok = 1'b0;
        sweep_regs();
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; run = 1'b0; din = '0; dbg_addr = '0;
    #35;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || illegal !== 1'b0 || alu_op !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b illegal=%b alu_op=%0d, want 0 0 0 0",
               busy, done, illegal, alu_op);
    end
    sweep_regs();
    for (int i = 0; i < 8; i++) begin
      ref_r[i] = '0;
      checks++;
      if (obs_r[i] !== 16'h0) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h want 0000", i, obs_r[i]);
      end
    end
    @(negedge clock); resetn = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] tins [15] = '{16'h2200, 16'h2400, 16'h5280, 16'h2600,
      16'h2800, 16'h6700, 16'h2600, 16'h8700, 16'h2A00, 16'h2C00,
      16'h9B80, 16'h2000, 16'h1140, 16'hF000, 16'h5240};
    logic [15:0] timm [15] = '{16'h0003, 16'h0005, 16'hAAAA, 16'h0002,
      16'h0007, 16'h5555, 16'h0002, 16'h0, 16'h00F0, 16'h0011,
      16'h0, 16'h1234, 16'h0, 16'h0, 16'h0};
    int          creg [15] = '{-1, -1, 1, -1, -1, 3, -1, 3, -1, -1,
      5, 0, 0, -1, 1};
    logic [15:0] cval [15] = '{16'h0, 16'h0, 16'h0008, 16'h0, 16'h0,
      16'hFFFB, 16'h0, 16'h0001, 16'h0, 16'h0, 16'h0000, 16'h1234,
      16'h0000, 16'h0, 16'h0010};
    int lat;
    logic ill, bok, ook;
    for (int t = 0; t < 15; t++) begin
      issue(tins[t], timm[t], lat, ill, bok, ook);
      model_step(tins[t], timm[t]);
      checks++;
      if (lat !== exp_lat(tins[t][15:12]) || ill !== is_illegal(tins[t][15:12])) begin
        errors++;
        $display("FAIL dir%0d_latency: ins=%h lat=%0d ill=%b want lat=%0d ill=%b",
                 t, tins[t], lat, ill, exp_lat(tins[t][15:12]), is_illegal(tins[t][15:12]));
      end
      checks++;
      if (!bok || !ook) begin
        errors++;
        $display("FAIL dir%0d_busy_aluop: ins=%h busy_ok=%b aluop_ok=%b want 1 1",
                 t, tins[t], bok, ook);
      end
      if (creg[t] >= 0) begin
        checks++;
        if (obs_r[creg[t]] !== cval[t]) begin
          errors++;
          $display("FAIL dir%0d_value: R%0d=%h want %h", t, creg[t], obs_r[creg[t]], cval[t]);
        end
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (obs_r[i] !== ref_r[i]) begin
          errors++;
          $display("FAIL dir%0d_reg%0d: got %h want %h", t, i, obs_r[i], ref_r[i]);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge clock); din = 16'h5280; run = 1'b1;
    @(negedge clock); run = 1'b0;
    @(negedge clock);
    checks++;
    if (alu_op !== 4'd5) begin
      errors++;
      $display("FAIL abort_in_exec: alu_op=%0d want 5", alu_op);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || alu_op !== 4'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: busy=%b alu_op=%0d done=%b want 0 0 0", busy, alu_op, done);
    end
    sweep_regs();
    for (int i = 0; i < 8; i++) begin
      ref_r[i] = '0;
      checks++;
      if (obs_r[i] !== 16'h0) begin
        errors++;
        $display("FAIL abort_reg%0d: got %h want 0000", i, obs_r[i]);
      end
    end
    @(negedge clock); resetn = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_done: %0d cycles with done/busy high, want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bad;
    logic ill, bok, ook;
    issue(16'h2200, 16'h0010, lat, ill, bok, ook);
    model_step(16'h2200, 16'h0010);
    issue(16'h2400, 16'h0003, lat, ill, bok, ook);
    model_step(16'h2400, 16'h0003);
    @(negedge clock); din = 16'h5280; run = 1'b1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (done !== (k % 4 == 3) || busy !== (k % 4 != 3)) bad++;
      if (k == 11) run = 1'b0;
    end
    sweep_regs();
    for (int n = 0; n < 3; n++) model_step(16'h5280, 16'h0);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_pattern: %0d cycles with wrong done/busy, want 0", bad);
    end
    checks++;
    if (obs_r[1] !== 16'h0019 || obs_r[1] !== ref_r[1]) begin
      errors++;
      $display("FAIL b2b_result: R1=%h want 0019", obs_r[1]);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: busy=%b want 0", busy);
    end
  endtask

  task automatic test_random();
    logic [15:0] ins, imm;
    int lat;
    logic ill, bok, ook;
    for (int t = 0; t < 60; t++) begin
      ins = 16'($urandom);
      if (t < 8) ins = {4'd2, t[2:0], 9'($urandom)};
      imm = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 20));
      issue(ins, imm, lat, ill, bok, ook);
      model_step(ins, imm);
      checks++;
      if (lat !== exp_lat(ins[15:12]) || ill !== is_illegal(ins[15:12])) begin
        errors++;
        $display("FAIL rnd%0d_latency: ins=%h lat=%0d ill=%b want lat=%0d ill=%b",
                 t, ins, lat, ill, exp_lat(ins[15:12]), is_illegal(ins[15:12]));
      end
      checks++;
      if (!bok || !ook) begin
        errors++;
        $display("FAIL rnd%0d_busy_aluop: ins=%h busy_ok=%b aluop_ok=%b want 1 1",
                 t, ins, bok, ook);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (obs_r[i] !== ref_r[i]) begin
          errors++;
          $display("FAIL rnd%0d_reg%0d: ins=%h got %h want %h", t, i, ins, obs_r[i], ref_r[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
